// File: rtl/mem_port_arbiter_if.sv
// Bundled requester, status and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [AW-1:0]     r0_addr;
    logic [DW-1:0]     r0_wdata;
    logic [DW/8-1:0]   r0_wstrb;
    logic              r0_done;

    logic              r1_req;
    logic              r1_we;
    logic [AW-1:0]     r1_addr;
    logic [DW-1:0]     r1_wdata;
    logic [DW/8-1:0]   r1_wstrb;
    logic              r1_done;

    logic [DW-1:0]     rdata;
    logic              busy;
    logic              owner;

    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic [DW-1:0]     mem_rdata;

    // Observation only: FSM state (0 IDLE, 1 ACCESS, 2 RESP) and starvation count.
    logic [1:0]        dbg_state;
    logic [3:0]        dbg_starve;

    // Handshake: req is held until the matching one-cycle done pulse; the
    // requester drops or replaces it on the edge after done.
    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_wstrb,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_wstrb,
        input  mem_rdata,
        output r0_done, r1_done, rdata, busy, owner,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output dbg_state, dbg_starve
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_wstrb,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_wstrb,
        output mem_rdata,
        input  r0_done, r1_done, rdata, busy, owner,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  dbg_state, dbg_starve
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port: fixed priority to r0 with
// an r1 anti-starvation counter, or round-robin ties when MEM_ARB_RR_EN is defined.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               resetn,
    mem_port_arbiter_if.slave  bus
);
    localparam int SW = DW / 8;
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      lat_cnt_q;
    logic            mem_en_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [SW-1:0]   mem_wstrb_q;
    logic            r0_done_q;
    logic            r1_done_q;
    logic [DW-1:0]   rdata_q;
    logic            busy_q;
    logic            owner_q;
    logic            win_r1;
    logic            any_req;

`ifdef MEM_ARB_RR_EN
    logic            last_owner_q;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0]      starve_cnt_q;
    logic [3:0]      starve_cnt_d;
`endif

    assign any_req = bus.r0_req | bus.r1_req;

    always_comb begin
        win_r1 = 1'b0;
        if (bus.r1_req && !bus.r0_req) begin
            win_r1 = 1'b1;
        end else if (bus.r1_req && bus.r0_req) begin
`ifdef MEM_ARB_RR_EN
            win_r1 = ~last_owner_q;
`else
            win_r1 = (starve_cnt_q == STARVE_LIM);
`endif
        end
    end

`ifndef MEM_ARB_RR_EN
    // Counts r0 wins over a waiting r1; only an r1 grant clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE && any_req) begin
            if (win_r1) begin
                starve_cnt_d = 4'd0;
            end else if (bus.r1_req && starve_cnt_q != STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            r0_done_q   <= 1'b0;
            r1_done_q   <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= 1'b1;
`else
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            r0_done_q <= 1'b0;
            r1_done_q <= 1'b0;
`ifndef MEM_ARB_RR_EN
            starve_cnt_q <= starve_cnt_d;
`endif
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        // The memory-side registers double as the latched request.
                        owner_q     <= win_r1;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= win_r1 ? bus.r1_we    : bus.r0_we;
                        mem_addr_q  <= win_r1 ? bus.r1_addr  : bus.r0_addr;
                        mem_wdata_q <= win_r1 ? bus.r1_wdata : bus.r0_wdata;
                        mem_wstrb_q <= win_r1 ? bus.r1_wstrb : bus.r0_wstrb;
                        lat_cnt_q   <= LAT_LOAD;
                        busy_q      <= 1'b1;
                        state_q     <= ACCESS;
`ifdef MEM_ARB_RR_EN
                        last_owner_q <= win_r1;
`endif
                    end
                end
                ACCESS: begin
                    if (lat_cnt_q == 4'd0) begin
                        rdata_q   <= bus.mem_rdata;
                        mem_en_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        r0_done_q <= ~owner_q;
                        r1_done_q <= owner_q;
                        state_q   <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.r0_done    = r0_done_q;
    assign bus.r1_done    = r1_done_q;
    assign bus.rdata      = rdata_q;
    assign bus.busy       = busy_q;
    assign bus.owner      = owner_q;
    assign bus.dbg_state  = state_q;
`ifdef MEM_ARB_RR_EN
    assign bus.dbg_starve = 4'd0;
`else
    assign bus.dbg_starve = starve_cnt_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=3 instance under directed and random
// traffic against a transaction-level model, plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 3;
  localparam int SMAX = 4;
  localparam logic [31:0] SALT = 32'h5A3C_9E17;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;

  req_t rq[2];
  bit   pend[2];
  int   r0_streak;
  bit   last_win;
  int   exp_order[10];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1)
  );

  // memory model: read data is a fixed function of the address
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ SALT;
  endfunction
  assign bus.mem_rdata = mem_model(bus.mem_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = 32'($urandom_range(0, 1023)) << 2;
    r.wdata = $urandom;
    r.wstrb = 4'($urandom_range(1, 15));
    return r;
  endfunction

  task automatic drive_reqs();
    bus.r0_req   = pend[0];
    bus.r0_we    = rq[0].we;
    bus.r0_addr  = rq[0].addr;
    bus.r0_wdata = rq[0].wdata;
    bus.r0_wstrb = rq[0].wstrb;
    bus.r1_req   = pend[1];
    bus.r1_we    = rq[1].we;
    bus.r1_addr  = rq[1].addr;
    bus.r1_wdata = rq[1].wdata;
    bus.r1_wstrb = rq[1].wstrb;
  endtask

  // Arbitration rules at transaction level: r0_streak is the number of r0
  // grants made while r1 waited since r1 was last served.
  task automatic model_pick(output int w);
    if (pend[0] && !pend[1]) w = 0;
    else if (!pend[0] && pend[1]) w = 1;
`ifdef MEM_ARB_RR_EN
    else w = last_win ? 0 : 1;
`else
    else w = (r0_streak >= SMAX) ? 1 : 0;
`endif
    if (w == 1) r0_streak = 0;
    else if (pend[1]) r0_streak++;
    last_win = (w == 1);
  endtask

  task automatic model_reset();
    r0_streak = 0;
    last_win = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
  endtask

  // Called at the negedge of an IDLE cycle; returns at the negedge of the
  // IDLE cycle that follows the transaction (or after one idle cycle).
  task automatic txn(input bit mid_change, input bit keep, output int w);
    drive_reqs();
    if (!pend[0] && !pend[1]) begin
      w = -1;
      @(negedge clk);
      chk("idle_mem_en", bus.mem_en, 0);
      chk("idle_busy", bus.busy, 0);
      return;
    end
    model_pick(w);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk("acc_mem_en", bus.mem_en, 1);
      chk("acc_mem_we", bus.mem_we, rq[w].we);
      chk("acc_mem_addr", bus.mem_addr, rq[w].addr);
      chk("acc_mem_wdata", bus.mem_wdata, rq[w].wdata);
      chk("acc_mem_wstrb", bus.mem_wstrb, rq[w].wstrb);
      chk("acc_owner", bus.owner, 64'(w));
      chk("acc_busy", bus.busy, 1);
      chk("acc_no_done", {bus.r0_done, bus.r1_done}, 0);
      if (mid_change && i == 0) begin
        if (w == 1) begin
          bus.r1_addr = 32'h99;
          bus.r1_wdata = ~rq[1].wdata;
        end else begin
          bus.r0_addr = 32'h99;
          bus.r0_wdata = ~rq[0].wdata;
        end
      end
    end
    @(negedge clk);
    chk("resp_r0_done", bus.r0_done, (w == 0));
    chk("resp_r1_done", bus.r1_done, (w == 1));
    chk("resp_mem_en", bus.mem_en, 0);
    chk("resp_busy", bus.busy, 1);
    if (!rq[w].we) chk("resp_rdata", bus.rdata, mem_model(rq[w].addr));
    if (!keep) pend[w] = 1'b0;
    drive_reqs();
    @(negedge clk);
    chk("post_done", {bus.r0_done, bus.r1_done}, 0);
    chk("post_mem_en", bus.mem_en, 0);
    chk("post_busy", bus.busy, 0);
  endtask

  initial begin
    int w;
    int exp_starve;
    rq[0] = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};
    rq[1] = rq[0];
    model_reset();
    drive_reqs();
    bus1.r0_req = 1'b0; bus1.r0_we = 1'b0; bus1.r0_addr = '0;
    bus1.r0_wdata = '0; bus1.r0_wstrb = '0;
    bus1.r1_req = 1'b0; bus1.r1_we = 1'b0; bus1.r1_addr = '0;
    bus1.r1_wdata = '0; bus1.r1_wstrb = '0;
    bus1.mem_rdata = 32'hDEAD_BEEF;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_state", bus.dbg_state, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wstrb", bus.mem_wstrb, 0);
    chk("rst_done", {bus.r0_done, bus.r1_done}, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_starve", bus.dbg_starve, 0);
    resetn = 1'b1;
    @(negedge clk);

    // MEM_LAT=1 instance: r0 read at 0x10
    bus1.r0_req = 1'b1;
    bus1.r0_addr = 32'h10;
    @(negedge clk);
    chk("l1_mem_en_t1", bus1.mem_en, 1);
    chk("l1_mem_addr", bus1.mem_addr, 32'h10);
    chk("l1_no_done_t1", {bus1.r0_done, bus1.r1_done}, 0);
    @(negedge clk);
    chk("l1_r0_done_t2", bus1.r0_done, 1);
    chk("l1_rdata", bus1.rdata, 32'hDEAD_BEEF);
    chk("l1_mem_en_t2", bus1.mem_en, 0);
    chk("l1_r1_done_t2", bus1.r1_done, 0);
    bus1.r0_req = 1'b0;
    @(negedge clk);
    chk("l1_after_done", {bus1.r0_done, bus1.r1_done, bus1.mem_en}, 0);

    // both requesting continuously
    rq[0] = rand_req(); rq[1] = rand_req();
    pend[0] = 1'b1; pend[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      txn(1'b0, 1'b0, w);
      chk($sformatf("order_owner_%0d", k), bus.owner, 64'(exp_order[k]));
      rq[w] = rand_req();
      pend[w] = 1'b1;
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    txn(1'b0, 1'b0, w);

    // r1 write with fields changing mid-access
    rq[1] = '{we: 1'b1, addr: 32'h20, wdata: 32'h1234_5678, wstrb: 4'hF};
    pend[1] = 1'b1;
    txn(1'b1, 1'b0, w);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          rq[r] = rand_req();
          pend[r] = 1'b1;
        end
      end
      txn(1'($urandom_range(0, 1)), 1'b0, w);
    end
    while (pend[0] || pend[1]) txn(1'b0, 1'b0, w);

    // r0 holds req one cycle past done: same request reissued, r1 untouched
    rq[0] = '{we: 1'b0, addr: 32'h44, wdata: 32'h0, wstrb: 4'hF};
    pend[0] = 1'b1;
    txn(1'b0, 1'b1, w);
    chk("hold_r1_done", bus.r1_done, 0);
    txn(1'b0, 1'b0, w);

    // reset in the second ACCESS cycle
    rq[0] = rand_req(); rq[1] = rand_req();
    pend[0] = 1'b1; pend[1] = 1'b1;
    drive_reqs();
    model_pick(w);
`ifdef MEM_ARB_RR_EN
    exp_starve = 0;
`else
    exp_starve = r0_streak;
`endif
    @(negedge clk);
    chk("pre_rst_starve", bus.dbg_starve, 64'(exp_starve));
    @(negedge clk);
    chk("pre_rst_mem_en", bus.mem_en, 1);
    resetn = 1'b0;
    model_reset();
    drive_reqs();
    @(negedge clk);
    chk("mid_rst_state", bus.dbg_state, 0);
    chk("mid_rst_mem_en", bus.mem_en, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", {bus.r0_done, bus.r1_done}, 0);
    chk("mid_rst_starve", bus.dbg_starve, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_done", {bus.r0_done, bus.r1_done, bus.mem_en}, 0);
    rq[0] = rand_req();
    pend[0] = 1'b1;
    txn(1'b0, 1'b0, w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: requester 0 is the multicycle core (fetch, load and store traffic); requester 1 is a secondary master such as the program loader or debug/DMA.
- Sequences each access over a fixed memory latency and returns read data with a one-cycle done pulse.
- Arbitrates by fixed priority to requester 0, with an anti-starvation counter that protects requester 1.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- MEM_LAT, 1, number of cycles mem_en is held per access; legal range 1..15; 0 is unsupported.
- STARVE_MAX, 4, number of consecutive requester-0 wins over a pending requester 1 before requester 1 is forced through; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- r0_req  in  1  requester 0 access request; held until r0_done.
- r0_we  in  1  requester 0 write enable.
- r0_addr  in  AW  requester 0 byte address.
- r0_wdata  in  DW  requester 0 write data.
- r0_wstrb  in  DW/8  requester 0 byte strobes.
- r0_done  out  1  requester 0 transaction complete, one-cycle pulse.
- r1_req, r1_we, r1_addr, r1_wdata, r1_wstrb  in  (same widths as requester 0)  requester 1 request fields.
- r1_done  out  1  requester 1 transaction complete, one-cycle pulse.
- rdata  out  DW  read data for the completing transaction; valid when either done is high.
- busy  out  1  high in ACCESS and RESP.
- owner  out  1  requester id of the current or most recent grant.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_wstrb  out  DW/8  memory byte strobes.
- mem_rdata  in  DW  memory read data; valid on the last ACCESS cycle.

Behaviour:
- Reset: clk and resetn are decided — reset resetn, synchronous, active-low; clock clk.
  - State returns to IDLE.
  - Outputs clear: mem_en=0, mem_we=0, mem_addr/mem_wdata/mem_wstrb=0, r0_done=r1_done=0, rdata=0, busy=0, owner=0.
  - Internal counters clear: starve_cnt=0, lat_cnt=0.
- Reset mid-transaction: the transaction is abandoned, no done pulse is issued, and mem_en drops at the reset edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick a winner and latch its we, addr, wdata and wstrb into internal registers.
  - Set owner to the winner; load lat_cnt = MEM_LAT-1; go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we = latched we; mem_addr, mem_wdata and mem_wstrb are driven from the latched registers. Requester field changes after the grant have no effect.
  - If lat_cnt==0: capture mem_rdata into rdata and go to RESP. Otherwise decrement lat_cnt.
- RESP:
  - Pulse done for the owner only, for one cycle; mem_en=0; go to IDLE.
  - rdata holds its value until the next capture. On writes, rdata is loaded with the mem_rdata sampled anyway and is don't-care to requesters.
- Latency: a req first seen in IDLE at cycle T gives mem_en in cycles T+1..T+MEM_LAT and done in cycle T+MEM_LAT+1. Minimum turnaround is MEM_LAT+2 cycles per transaction.
- Requester rule: deassert req, or present a new request, on the edge after done. RESP always returns to IDLE, so a stale held req simply becomes a fresh request; no combinational path from req to done exists.
- Arbitration in IDLE:
  - Only one req high: that requester wins.
  - Both high and starve_cnt < STARVE_MAX: requester 0 wins and starve_cnt increments, saturating at STARVE_MAX.
  - Both high and starve_cnt == STARVE_MAX: requester 1 wins.
  - Any requester-1 grant clears starve_cnt.
  - A requester-0 grant with r1_req low leaves starve_cnt unchanged.
- Simultaneous events: a req arriving during ACCESS or RESP waits; it is arbitrated on the next IDLE cycle.
- Never more than one done per transaction, and never both done signals in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- When defined:
  - Ties are resolved by round-robin: the requester not equal to the last_owner register wins.
  - last_owner resets to 1, so requester 0 wins the first tie.
  - starve_cnt and STARVE_MAX are unused; starve_cnt may be removed.
- When undefined: fixed priority with the starvation counter as described above.

Test Plan:
- MEM_LAT=1, r0 read addr 0x10 with mem_rdata=0xDEADBEEF -> mem_en high exactly cycle T+1, r0_done and rdata=0xDEADBEEF at T+2, r1_done never asserted.
- MEM_LAT=3, r1 write addr 0x20, wdata 0x12345678, wstrb 0xF -> mem_we=mem_en=1 for 3 cycles with latched fields; r1 changes r1_addr to 0x99 mid-access and mem_addr stays 0x20; r1_done at T+4.
- STARVE_MAX=4, r0 and r1 requesting continuously -> grant order 0,0,0,0,1,0,0,0,0,1; owner and done signals match.
- Reset asserted in the second ACCESS cycle with MEM_LAT=3 -> next cycle IDLE, mem_en=0, no done, starve_cnt=0, then a new r0 request completes normally.
- With MEM_ARB_RR_EN, both requesting continuously -> grants alternate 0,1,0,1; with only r0 requesting -> back-to-back r0 grants every MEM_LAT+2 cycles.
- r0 holds req for one extra cycle after done -> a second r0 transaction is issued to the same address (documented behaviour), with no glitch on r1_done.
